// File: rtl/bpm_beat_tracker.sv
// Tempo tracker: range-gates BPM estimates, smooths them, locks, and emits beat pulses.
// Optional reject counter output is enabled with `define BPM_REJECT_COUNT_EN.
module bpm_beat_tracker #(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned MIN_BPM        = 40,
  parameter int unsigned MAX_BPM        = 240,
  parameter int unsigned LOCK_TOL       = 4,
  parameter int unsigned LOCK_COUNT     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] bpm_in,
  input  logic        bpm_valid,
  output logic [15:0] bpm_smoothed,
  output logic        bpm_locked,
  output logic        beat_pulse,
`ifdef BPM_REJECT_COUNT_EN
  output logic [7:0]  reject_count,
`endif
  output logic [1:0]  dbg_state
);

  localparam int L  = $clog2(DEPTH);
  localparam int SW = 16 + L;
  localparam logic [63:0] THRESH64 = 64'(CLK_HZ) * 64'd60;
  localparam logic [32:0] THRESH   = THRESH64[32:0];
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  // bpm_valid is a one-cycle qualifier with no backpressure: every valid sample is consumed.
  state_e         state_q, state_d;
  logic [15:0]    ring_q [DEPTH];
  logic [15:0]    ring_d [DEPTH];
  logic [L-1:0]   ptr_q, ptr_d;
  logic [SW-1:0]  sum_q, sum_d;
  logic [15:0]    smoothed_q, smoothed_d;
  logic [7:0]     stable_q, stable_d;
  logic [31:0]    timer_q, timer_d;
  logic [32:0]    acc_q, acc_d, acc_sum;
  logic           beat_q, beat_d;

  logic        in_range, accept, expire, stable;
  logic [16:0] delta, diff;

  assign in_range = (bpm_in >= 16'(MIN_BPM)) && (bpm_in <= 16'(MAX_BPM));
  assign accept   = bpm_valid && in_range;
  assign expire   = (state_q != IDLE) && !accept && (timer_q == TO_LAST);
  assign delta    = {1'b0, bpm_in} - {1'b0, smoothed_q};
  assign diff     = delta[16] ? (~delta + 17'd1) : delta;
  assign stable   = diff <= 17'(LOCK_TOL);
  assign acc_sum  = acc_q + {17'd0, smoothed_q};

  always_comb begin
    state_d    = state_q;
    ring_d     = ring_q;
    ptr_d      = ptr_q;
    sum_d      = sum_q;
    stable_d   = stable_q;
    smoothed_d = sum_q[SW-1:L];
    acc_d      = '0;
    beat_d     = 1'b0;
    timer_d    = accept ? '0 : ((timer_q == TO_LAST) ? timer_q : timer_q + 32'd1);

    if (accept && state_q != IDLE) begin
      ring_d[ptr_q] = bpm_in;
      sum_d         = sum_q + SW'(bpm_in) - SW'(ring_q[ptr_q]);
      ptr_d         = ptr_q + L'(1);
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          for (int i = 0; i < DEPTH; i++) ring_d[i] = bpm_in;
          sum_d    = SW'(bpm_in) << L;
          stable_d = '0;
          state_d  = ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (accept) begin
          if (stable) begin
            stable_d = stable_q + 8'd1;
            if (stable_q + 8'd1 >= 8'(LOCK_COUNT)) state_d = LOCKED;
          end else begin
            stable_d = '0;
          end
        end
      end
      LOCKED: begin
        if (accept && !stable) begin
          stable_d = '0;
          state_d  = ACQUIRE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (expire) begin
      state_d    = IDLE;
      for (int i = 0; i < DEPTH; i++) ring_d[i] = '0;
      sum_d      = '0;
      smoothed_d = '0;
      stable_d   = '0;
    end

    // Phase only advances while staying locked; entering or leaving LOCKED leaves acc at 0.
    if (state_q == LOCKED && state_d == LOCKED) begin
      if (acc_sum >= THRESH) begin
        acc_d  = acc_sum - THRESH;
        beat_d = 1'b1;
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      ptr_q      <= '0;
      sum_q      <= '0;
      smoothed_q <= '0;
      stable_q   <= '0;
      timer_q    <= '0;
      acc_q      <= '0;
      beat_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_q     <= ring_d;
      ptr_q      <= ptr_d;
      sum_q      <= sum_d;
      smoothed_q <= smoothed_d;
      stable_q   <= stable_d;
      timer_q    <= timer_d;
      acc_q      <= acc_d;
      beat_q     <= beat_d;
    end
  end

`ifdef BPM_REJECT_COUNT_EN
  logic [7:0] rej_q, rej_d;
  assign rej_d = (bpm_valid && !in_range && rej_q != 8'hFF) ? rej_q + 8'd1 : rej_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rej_q <= '0;
    else          rej_q <= rej_d;
  end

  assign reject_count = rej_q;
`endif

  assign bpm_smoothed = smoothed_q;
  assign bpm_locked   = (state_q == LOCKED);
  assign beat_pulse   = beat_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_bpm_beat_tracker.sv
// Directed bench for bpm_beat_tracker: lock, metronome timing, rejection, timeout, reset.
module tb_bpm_beat_tracker;

  localparam int S_IDLE = 0;
  localparam int S_ACQ  = 1;
  localparam int S_LOCK = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] bpm_in = '0;
  logic        bpm_valid = 1'b0;
  logic [15:0] bpm_smoothed;
  logic        bpm_locked;
  logic        beat_pulse;
  logic [1:0]  dbg_state;
`ifdef BPM_REJECT_COUNT_EN
  logic [7:0]  reject_count;
`endif

  bpm_beat_tracker #(
    .CLK_HZ(1000), .DEPTH(4), .MIN_BPM(40), .MAX_BPM(240),
    .LOCK_TOL(2), .LOCK_COUNT(3), .TIMEOUT_CYCLES(5000)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bpm_in(bpm_in), .bpm_valid(bpm_valid),
    .bpm_smoothed(bpm_smoothed), .bpm_locked(bpm_locked), .beat_pulse(beat_pulse),
`ifdef BPM_REJECT_COUNT_EN
    .reject_count(reject_count),
`endif
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] m_win[4];
  int          m_ptr  = 0;
  bit          m_idle = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called right after a negedge; the sample is taken at the following posedge.
  task automatic send(input logic [15:0] v);
    int s;
    bpm_in    = v;
    bpm_valid = 1'b1;
    if (v >= 16'd40 && v <= 16'd240) begin
      if (m_idle) begin
        for (int i = 0; i < 4; i++) m_win[i] = v;
        m_idle = 1'b0;
      end else begin
        m_win[m_ptr] = v;
        m_ptr = (m_ptr + 1) % 4;
      end
      s = 0;
      for (int i = 0; i < 4; i++) s += int'(m_win[i]);
      exp_q.push_back(16'(s / 4));
    end
    @(negedge clk);
    bpm_valid = 1'b0;
  endtask

  task automatic check_avg(input string tag);
    logic [15:0] e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: observed %0d expected <no scoreboard entry>", tag, bpm_smoothed);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(bpm_smoothed), 32'(e));
    end
  endtask

  task automatic wait_beat(input int limit, output int k);
    k = 0;
    while (k < limit) begin
      @(negedge clk);
      k++;
      if (beat_pulse) break;
    end
  endtask

  task automatic wait_idle(input int start, output int el, output int beats);
    el = start;
    beats = 0;
    while (dbg_state != 2'(S_IDLE) && el < 7000) begin
      @(negedge clk);
      el++;
      if (beat_pulse) beats++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, el, beats;

    repeat (3) @(negedge clk);
    check("reset_smoothed", 32'(bpm_smoothed), 0);
    check("reset_locked", 32'(bpm_locked), 0);
    check("reset_beat", 32'(beat_pulse), 0);
    check("reset_state", 32'(dbg_state), S_IDLE);
`ifdef BPM_REJECT_COUNT_EN
    check("reset_rejects", 32'(reject_count), 0);
`endif
    reset_n = 1'b1;
    @(negedge clk);

    // Acquire and lock on 120 / 120 / 121 / 119
    send(16'd120);
    check_avg("prefill_avg");
    check("acq_state", 32'(dbg_state), S_ACQ);
    check("acq_unlocked", 32'(bpm_locked), 0);
    repeat (98) @(negedge clk);
    send(16'd120);
    check_avg("avg_120");
    repeat (98) @(negedge clk);
    send(16'd121);
    check_avg("avg_121");
    repeat (98) @(negedge clk);
    send(16'd119);
    check("lock_state", 32'(dbg_state), S_LOCK);
    check_avg("avg_119");
    check("locked_flag", 32'(bpm_locked), 1);

    wait_beat(2000, k);
    check("first_beat_delay", 32'(k + 1), 500);
    @(negedge clk);
    check("beat_width", 32'(beat_pulse), 0);
    wait_beat(2000, k);
    check("beat_period", 32'(k + 1), 500);
    @(negedge clk);

    // Large deviation drops lock
    send(16'd200);
    check("unlock_state", 32'(dbg_state), S_ACQ);
    check("unlock_flag", 32'(bpm_locked), 0);
    check_avg("avg_after_200");

    // Out-of-range samples are ignored and do not reload the timer
    send(16'd20);
    send(16'd300);
    check("reject_state", 32'(dbg_state), S_ACQ);
    check("reject_hold_avg", 32'(bpm_smoothed), 140);
`ifdef BPM_REJECT_COUNT_EN
    check("reject_count_2", 32'(reject_count), 2);
`endif
    wait_idle(3, el, beats);
    check("acq_timeout_cycles", 32'(el), 5000);
    check("no_beats_unlocked", 32'(beats), 0);
    check("timeout_avg", 32'(bpm_smoothed), 0);
    check("timeout_unlocked", 32'(bpm_locked), 0);

    // Relock at 100, then a sample on the expiry cycle keeps the lock
    m_idle = 1'b1;
    send(16'd100);
    check_avg("relock_avg0");
    send(16'd100);
    check_avg("relock_avg1");
    send(16'd100);
    check_avg("relock_avg2");
    send(16'd100);
    check_avg("relock_avg3");
    check("relock_state", 32'(dbg_state), S_LOCK);
    repeat (4998) @(negedge clk);
    check("pre_expiry_locked", 32'(dbg_state), S_LOCK);
    send(16'd100);
    check("expiry_sample_wins", 32'(dbg_state), S_LOCK);
    check_avg("expiry_avg");
    wait_idle(1, el, beats);
    check("lock_timeout_cycles", 32'(el), 5000);
    check("lock_timeout_avg", 32'(bpm_smoothed), 0);
    check("lock_timeout_unlocked", 32'(bpm_locked), 0);

    // Asynchronous reset while locked, then restart
    m_idle = 1'b1;
    send(16'd100);
    check_avg("rst_lock_avg0");
    repeat (3) begin
      send(16'd100);
      check_avg("rst_lock_avgn");
    end
    repeat (300) @(negedge clk);
    check("pre_reset_locked", 32'(bpm_locked), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_smoothed", 32'(bpm_smoothed), 0);
    check("async_rst_locked", 32'(bpm_locked), 0);
    check("async_rst_beat", 32'(beat_pulse), 0);
    check("async_rst_state", 32'(dbg_state), S_IDLE);
    @(negedge clk);
    reset_n = 1'b1;
    m_idle = 1'b1;
    send(16'd90);
    check("restart_state", 32'(dbg_state), S_ACQ);
    check_avg("restart_avg");

`ifdef BPM_REJECT_COUNT_EN
    check("rejects_after_reset", 32'(reject_count), 0);
    repeat (260) send(16'd7);
    check("reject_saturate", 32'(reject_count), 255);
`endif

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
